// File: rtl/dmx_frame_router_pkg.sv
// dmx_pkg: shared state encoding and address width for the DMX frame router.
package dmx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
  localparam int ADDR_BITS = 3;
  localparam int NUM_DEST = 1 << ADDR_BITS;
endpackage

// File: rtl/dmx_frame_router_if.sv
// dmx_frame_router_if: serial frame input and routed payload output bundle.
interface dmx_frame_router_if;
  logic start;
  logic din;
  logic din_valid;
  logic [dmx_pkg::NUM_DEST-1:0] y;
  logic y_valid;
  logic [dmx_pkg::ADDR_BITS-1:0] sel;
  logic busy;
  logic done;
  logic err;
  modport master(output start, din, din_valid, input y, y_valid, sel, busy, done, err);
  modport slave(input start, din, din_valid, output y, y_valid, sel, busy, done, err);
endinterface

// File: rtl/dmx_frame_router_demux.sv
// demux_1x8: steers a single payload bit onto the output lane chosen by s.
module demux_1x8 (
  input  logic       i,
  input  logic [2:0] s,
  output logic [7:0] o
);
  assign o = {7'b0, i} << s;
endmodule

// File: rtl/dmx_frame_router.sv
// dmx_frame_router: captures a 3-bit address then routes PAYLOAD_LEN serial
// payload bits onto the selected output lane, one registered beat at a time.
module dmx_frame_router
  import dmx_pkg::*;
#(
  parameter int PAYLOAD_LEN = 8
) (
  input logic                clk,
  input logic                rst_n,
  dmx_frame_router_if.slave  bus
);
  localparam int PW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [PW-1:0] LAST = PW'(PAYLOAD_LEN - 1);
  state_t                r_state, w_state;
  logic [1:0]            r_acnt, w_acnt;
  logic [PW-1:0]         r_pcnt, w_pcnt;
  logic [ADDR_BITS-1:0]  r_sel, w_sel;
  logic [NUM_DEST-1:0]   r_y, w_y, w_demux;
  logic                  r_yv, w_yv, r_done, w_done, r_err, w_err, r_busy, w_busy;
  demux_1x8 u_demux (.i(bus.din), .s(r_sel), .o(w_demux));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acnt  <= '0;
      r_pcnt  <= '0;
      r_sel   <= '0;
      r_y     <= '0;
      r_yv    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_acnt  <= w_acnt;
      r_pcnt  <= w_pcnt;
      r_sel   <= w_sel;
      r_y     <= w_y;
      r_yv    <= w_yv;
      r_done  <= w_done;
      r_err   <= w_err;
      r_busy  <= w_busy;
    end
  end
  // A valid start always wins: it opens a frame from IDLE or aborts one in flight.
  always_comb begin
    w_state = r_state;
    w_acnt  = r_acnt;
    w_pcnt  = r_pcnt;
    w_sel   = r_sel;
    w_y     = '0;
    w_yv    = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    if (bus.din_valid) begin
      if (bus.start) begin
        w_err   = r_state != IDLE;
        w_state = ADDR;
        w_acnt  = 2'd1;
        w_pcnt  = '0;
        w_sel   = {bus.din, r_sel[1:0]};
      end else if (r_state == ADDR) begin
        w_sel   = r_acnt == 2'd1 ? {r_sel[2], bus.din, r_sel[0]} : {r_sel[2:1], bus.din};
        w_acnt  = r_acnt == 2'(ADDR_BITS - 1) ? 2'd0 : r_acnt + 2'd1;
        w_state = r_acnt == 2'(ADDR_BITS - 1) ? DATA : ADDR;
        w_pcnt  = '0;
      end else if (r_state == DATA) begin
        w_y     = w_demux;
        w_yv    = 1'b1;
        w_done  = r_pcnt == LAST;
        w_state = r_pcnt == LAST ? IDLE : DATA;
        w_pcnt  = r_pcnt == LAST ? '0 : r_pcnt + 1'b1;
      end
    end
    w_busy = w_state != IDLE;
  end
  assign bus.y       = r_y;
  assign bus.y_valid = r_yv;
  assign bus.sel     = r_sel;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
endmodule

// File: doc/dmx_frame_router.md
DMX_FRAME_ROUTER -- requirements
Module: dmx_frame_router

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 8, meaning the number of payload bits per frame (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  frame-start strobe; qualified by din_valid and marks the first address bit.
REQ-005 SHALL have port din  input  1  serial frame data: 3 address bits MSB-first, then PAYLOAD_LEN payload bits.
REQ-006 SHALL have port din_valid  input  1  din (and start) are valid this cycle.
REQ-007 SHALL have port y  output  8  routed payload; at most one bit is driven from payload, all other bits are 0.
REQ-008 SHALL have port y_valid  output  1  y carries a payload bit this cycle.
REQ-009 SHALL have port sel  output  3  latched destination address of the current or last frame.
REQ-010 SHALL have port busy  output  1  high in ADDR or DATA state.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last payload bit of a frame is routed.
REQ-012 SHALL have port err  output  1  one-cycle pulse when a frame is aborted by a new start.

Function
REQ-013 SHALL implement the FSM states IDLE, ADDR and DATA.
REQ-014 IDLE: start=1 and din_valid=1 -> sel[2]<=din, addr count<=1, go to ADDR; start without din_valid SHALL be ignored.
REQ-015 ADDR: each valid beat shifts din into sel (MSB-first); on the 3rd address bit the FSM goes to DATA with payload count=0.
REQ-016 DATA: each valid beat SHALL register y[sel]<=din, other y bits<=0, y_valid<=1 (1-cycle latency, din to y).
REQ-017 DATA: on the beat where payload count reaches PAYLOAD_LEN-1, the FSM SHALL go to IDLE, and done SHALL be 1 in the same cycle that the last bit appears on y.
REQ-018 Cycles with din_valid=0 SHALL stall: state and counters hold, and y=0, y_valid=0 next cycle.
REQ-019 When y_valid=0, y SHALL be 8'h00.
REQ-020 Simultaneous events: start=1 with din_valid=1 in ADDR or DATA SHALL abort the frame, pulse err next cycle, and restart address capture with this din as the address MSB (state ADDR, addr count=1); the bit is not routed.
REQ-021 Abort SHALL NOT assert done.
REQ-022 start=1 on the last payload beat SHALL count as an abort (err=1, done=0).
REQ-023 The payload counter SHALL be $clog2(PAYLOAD_LEN+1) bits wide and SHALL never exceed PAYLOAD_LEN-1.
REQ-024 sel SHALL hold its value in IDLE until the next start.
REQ-025 A new frame's start is accepted in the cycle immediately after the last payload beat (back-to-back frames, no gap cycle).

Reset
REQ-026 When rst_n=0, the block SHALL asynchronously force state=IDLE, counters=0, sel=0, y=0, y_valid=0, busy=0, done=0 and err=0.
REQ-027 Reset asserted mid-frame SHALL discard the frame with no done or err pulse; after release, the block waits for start.
REQ-028 Release of rst_n SHALL take effect on the first rising clk edge after deassertion.

Structure
REQ-029 SHALL place the state encoding (IDLE=0, ADDR=1, DATA=2) and ADDR_BITS=3 in the shared package dmx_pkg.
REQ-030 SHALL route payload through one sub-module, demux_1x8, with i=din, s=sel and output registered into y.
REQ-031 All outputs SHALL be registered; the FSM SHALL have no combinational input-to-output path.

Verification
REQ-032 Reset, then start with address 1,0,1 and payload 10110011 (all valid) -> sel=5; y[5] follows 1,0,1,1,0,0,1,1 one cycle late; y_valid high for 8 cycles; done high on the 8th; err=0.
REQ-033 Address 000, with din_valid deasserted for 2 cycles after payload bit 3 -> y_valid low for 2 cycles; y[0] sequence intact; done after 8 routed bits.
REQ-034 Start again at payload bit 4 of an address-011 frame -> err pulse; no done; the new address is captured from the restart bit; the new frame routes correctly.
REQ-035 Two back-to-back frames, addresses 111 then 010, no gap -> two done pulses 11 cycles apart; y[7] then y[2] active; never more than one y bit set.
REQ-036 rst_n dropped mid-DATA for 1 cycle -> all outputs 0 immediately; no done or err; a subsequent frame works.
REQ-037 PAYLOAD_LEN=1, address 100, payload 1 -> y=8'h10 and done in the same cycle; busy low the next cycle.
